// File: rtl/mips_fetch_regs.sv
// rtl/mips_fetch_regs.sv - PC/IR/MDR/ALUOut datapath registers and fetch wait FSM for a multicycle MIPS
module mips_fetch_regs #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] RESET_IR = 32'h0000_0000,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clock,
    input  logic        rst,
    input  logic        PC_write,
    input  logic        Branch,
    input  logic        zero,
    input  logic        Pc_src_mux,
    input  logic        lorD_mux,
    input  logic        IR_write,
    input  logic [31:0] alu_result,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] pc,
    output logic [31:0] alu_out,
    output logic [31:0] instr,
    output logic [5:0]  op,
    output logic [5:0]  Funct,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [31:0] imm_sext,
    output logic [31:0] mdr,
    output logic        ir_valid,
    output logic        stall,
    output logic        mem_err
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

    state_t      state;
    logic [7:0]  wait_cnt;
    logic [31:0] req_addr;
    logic        pc_load;

    assign pc_load  = PC_write | (Branch & zero);

    // The address is frozen while a fetch is pending so PC moves cannot disturb it.
    assign mem_addr = (state == S_WAIT) ? req_addr : (lorD_mux ? alu_out : pc);

    assign op       = instr[31:26];
    assign rs       = instr[25:21];
    assign rt       = instr[20:16];
    assign rd       = instr[15:11];
    assign Funct    = instr[5:0];
    assign imm_sext = {{16{instr[15]}}, instr[15:0]};

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            pc       <= RESET_PC;
            instr    <= RESET_IR;
            alu_out  <= 32'd0;
            mdr      <= 32'd0;
            ir_valid <= 1'b0;
            stall    <= 1'b0;
            mem_err  <= 1'b0;
            state    <= S_IDLE;
            wait_cnt <= 8'd0;
            req_addr <= 32'd0;
        end else begin
            alu_out <= alu_result;
            if (pc_load) begin
                pc <= Pc_src_mux ? alu_out : alu_result;
            end
            if (mem_ready) begin
                mdr <= mem_rdata;
            end
            case (state)
                S_IDLE: begin
                    if (IR_write) begin
                        if (mem_ready) begin
                            instr    <= mem_rdata;
                            ir_valid <= 1'b1;
                        end else begin
                            req_addr <= mem_addr;
                            wait_cnt <= 8'd1;
                            stall    <= 1'b1;
                            state    <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (mem_ready) begin
                        instr    <= mem_rdata;
                        ir_valid <= 1'b1;
                        stall    <= 1'b0;
                        state    <= S_IDLE;
                    end else if (wait_cnt == WAIT_LIMIT) begin
                        mem_err  <= 1'b1;
                        stall    <= 1'b0;
                        state    <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: begin
                    stall <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_fetch_regs.sv
// tb/tb_mips_fetch_regs.sv - self-checking bench for mips_fetch_regs with an instruction scoreboard
module tb_mips_fetch_regs;

    logic        clock = 1'b0;
    logic        rst;
    logic        PC_write, Branch, zero, Pc_src_mux, lorD_mux, IR_write;
    logic [31:0] alu_result, mem_rdata;
    logic        mem_ready;
    logic [31:0] mem_addr, pc, alu_out, instr, imm_sext, mdr;
    logic [5:0]  op, Funct;
    logic [4:0]  rs, rt, rd;
    logic        ir_valid, stall, mem_err;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_instr;
    logic [31:0] last_instr;

    mips_fetch_regs #(
        .RESET_PC (32'h0000_0000),
        .RESET_IR (32'h0000_0000),
        .MAX_WAIT (4)
    ) dut (
        .clock      (clock),
        .rst        (rst),
        .PC_write   (PC_write),
        .Branch     (Branch),
        .zero       (zero),
        .Pc_src_mux (Pc_src_mux),
        .lorD_mux   (lorD_mux),
        .IR_write   (IR_write),
        .alu_result (alu_result),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .mem_addr   (mem_addr),
        .pc         (pc),
        .alu_out    (alu_out),
        .instr      (instr),
        .op         (op),
        .Funct      (Funct),
        .rs         (rs),
        .rt         (rt),
        .rd         (rd),
        .imm_sext   (imm_sext),
        .mdr        (mdr),
        .ir_valid   (ir_valid),
        .stall      (stall),
        .mem_err    (mem_err)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        PC_write = 0; Branch = 0; zero = 0; Pc_src_mux = 0; lorD_mux = 0;
        IR_write = 0; mem_ready = 0;
    endtask

    task automatic test_reset();
        rst = 1; idle_inputs(); alu_result = 32'h77; mem_rdata = 32'hFFFF_FFFF;
        tick(); tick();
        #2 rst = 0;
        #1;
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp %h", pc, 32'h0); end
        checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr got %h exp %h", instr, 32'h0); end
        checks++; if (op !== 6'h0 || Funct !== 6'h0) begin errors++; $display("FAIL reset_decode got %h/%h exp 0/0", op, Funct); end
        checks++; if ({stall, ir_valid, mem_err} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {stall, ir_valid, mem_err}); end
        tick();
        rst = 1;
        tick();
        checks++; if (alu_out !== 32'h77) begin errors++; $display("FAIL alu_out_lag got %h exp %h", alu_out, 32'h77); end
        last_instr = 32'h0;
    endtask

    task automatic test_zero_wait();
        mem_rdata = 32'h2008_0005; IR_write = 1; mem_ready = 1;
        exp_q.push_back(32'h2008_0005);
        tick();
        IR_write = 0; mem_ready = 0;
        exp_instr = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
        checks++; if (instr !== exp_instr) begin errors++; $display("FAIL hit_instr got %h exp %h", instr, exp_instr); end
        checks++; if (op !== 6'b001000 || rt !== 5'd8) begin errors++; $display("FAIL hit_fields got op=%h rt=%0d exp op=08 rt=8", op, rt); end
        checks++; if (imm_sext !== 32'd5) begin errors++; $display("FAIL hit_imm got %h exp %h", imm_sext, 32'd5); end
        checks++; if (ir_valid !== 1'b1) begin errors++; $display("FAIL hit_ir_valid got %b exp 1", ir_valid); end
        last_instr = exp_instr;
    endtask

    task automatic test_miss();
        int n;
        PC_write = 1; alu_result = 32'd4; Pc_src_mux = 0;
        tick();
        PC_write = 0;
        checks++; if (pc !== 32'd4) begin errors++; $display("FAIL miss_setup_pc got %h exp 4", pc); end
        IR_write = 1; mem_ready = 0; mem_rdata = 32'h012A_4020;
        #1;
        checks++; if (mem_addr !== 32'd4) begin errors++; $display("FAIL miss_req_addr got %h exp 4", mem_addr); end
        exp_q.push_back(32'h012A_4020);
        tick();
        IR_write = 0;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            if (!stall) break;
            n++;
            if (mem_addr !== 32'd4) begin
                errors++; $display("FAIL miss_addr_hold cycle %0d got %h exp 4", n, mem_addr);
            end
            checks++;
            mem_ready = (n == 3);
            PC_write = (n == 1); alu_result = 32'd8;
            tick();
        end
        mem_ready = 0; PC_write = 0;
        checks++; if (n !== 3) begin errors++; $display("FAIL miss_stall_cycles got %0d exp 3", n); end
        checks++; if (pc !== 32'd8) begin errors++; $display("FAIL miss_pc got %h exp 8", pc); end
        exp_instr = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
        checks++; if (instr !== exp_instr) begin errors++; $display("FAIL miss_instr got %h exp %h", instr, exp_instr); end
        checks++; if (Funct !== 6'b100000 || rd !== 5'd8) begin errors++; $display("FAIL miss_fields got Funct=%h rd=%0d exp 20/8", Funct, rd); end
        last_instr = exp_instr;
    endtask

    task automatic test_timeout();
        int n;
        IR_write = 1; mem_ready = 0; mem_rdata = 32'hBAD0_BAD0;
        tick();
        IR_write = 0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (!stall) break;
            n++;
            tick();
        end
        checks++; if (n !== 4) begin errors++; $display("FAIL timeout_stall_cycles got %0d exp 4", n); end
        checks++; if (mem_err !== 1'b1) begin errors++; $display("FAIL timeout_mem_err got %b exp 1", mem_err); end
        checks++; if (instr !== last_instr) begin errors++; $display("FAIL timeout_instr got %h exp %h", instr, last_instr); end
        mem_ready = 1; IR_write = 1; mem_rdata = 32'h2008_0005;
        exp_q.push_back(32'h2008_0005);
        tick();
        mem_ready = 0; IR_write = 0;
        exp_instr = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
        checks++; if (instr !== exp_instr || stall !== 1'b0) begin errors++; $display("FAIL timeout_back_idle got instr=%h stall=%b exp %h 0", instr, stall, exp_instr); end
        checks++; if (mem_err !== 1'b1) begin errors++; $display("FAIL mem_err_sticky got %b exp 1", mem_err); end
        last_instr = exp_instr;
    endtask

    task automatic test_pc_control();
        logic [31:0] a, b, wrap;
        Branch = 1; zero = 0; alu_result = 32'h123;
        tick();
        checks++; if (pc !== 32'd8) begin errors++; $display("FAIL branch_not_taken got %h exp 8", pc); end
        Branch = 0; alu_result = 32'h40;
        tick();
        Branch = 1; zero = 1; Pc_src_mux = 1; alu_result = 32'h99;
        tick();
        Branch = 0; zero = 0; Pc_src_mux = 0;
        checks++; if (pc !== 32'h40) begin errors++; $display("FAIL branch_taken got %h exp %h", pc, 32'h40); end
        a = 32'hFFFF_FFFC; b = 32'd4; wrap = a + b;
        PC_write = 1; alu_result = wrap;
        tick();
        PC_write = 0;
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL pc_wrap got %h exp 0", pc); end
    endtask

    task automatic test_lord();
        alu_result = 32'h100;
        tick();
        lorD_mux = 1; mem_ready = 1; IR_write = 0; mem_rdata = 32'hDEAD_BEEF;
        #1;
        checks++; if (mem_addr !== 32'h100) begin errors++; $display("FAIL lord_addr got %h exp %h", mem_addr, 32'h100); end
        tick();
        lorD_mux = 0; mem_ready = 0;
        checks++; if (mdr !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lord_mdr got %h exp %h", mdr, 32'hDEAD_BEEF); end
        checks++; if (instr !== last_instr) begin errors++; $display("FAIL lord_instr got %h exp %h", instr, last_instr); end
    endtask

    task automatic test_reset_mid_wait();
        IR_write = 1; mem_ready = 0;
        tick();
        IR_write = 0;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL midwait_stall_set got %b exp 1", stall); end
        #2 rst = 0;
        #1;
        checks++; if (stall !== 1'b0 || instr !== 32'h0) begin errors++; $display("FAIL midwait_reset got stall=%b instr=%h exp 0 0", stall, instr); end
        checks++; if ({ir_valid, mem_err} !== 2'b00 || pc !== 32'h0) begin errors++; $display("FAIL midwait_flags got %b pc=%h exp 00 0", {ir_valid, mem_err}, pc); end
        tick();
        rst = 1;
        tick();
        mem_ready = 1; mem_rdata = 32'hCAFE_F00D;
        tick();
        mem_ready = 0;
        checks++; if (instr !== 32'h0) begin errors++; $display("FAIL late_ready_instr got %h exp 0", instr); end
        checks++; if (mdr !== 32'hCAFE_F00D || stall !== 1'b0) begin errors++; $display("FAIL late_ready_mdr got %h stall=%b exp %h 0", mdr, stall, 32'hCAFE_F00D); end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_miss();
        test_timeout();
        test_pc_control();
        test_lord();
        test_reset_mid_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_fetch_regs.md
# mips_fetch_regs

Upstream companion of the multicycle MIPS control FSM. It holds the program counter, the instruction register (IR), the memory data register (MDR) and the ALUOut register. It selects the memory address and waits on a variable-latency memory for instruction fetches. It decodes the IR into the `op`/`Funct` fields the control FSM consumes, and applies that FSM's `PC_write`, `Branch`, `Pc_src_mux`, `lorD_mux` and `IR_write` strobes.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC value after reset.
- `RESET_IR`, 32'h0000_0000, IR value after reset.
- `MAX_WAIT`, 15, maximum cycles a fetch may wait for `mem_ready` before it is abandoned (1..255).

Ports:
- `clock`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `PC_write`  in  1  unconditional PC load.
- `Branch`  in  1  conditional PC load, qualified by `zero`.
- `zero`  in  1  ALU zero flag.
- `Pc_src_mux`  in  1  next-PC select: 0 = `alu_result`, 1 = ALUOut register.
- `lorD_mux`  in  1  address select: 0 = PC, 1 = ALUOut register.
- `IR_write`  in  1  instruction-fetch request.
- `alu_result`  in  32  combinational ALU output.
- `mem_rdata`  in  32  memory read data, valid when `mem_ready`.
- `mem_ready`  in  1  memory read data valid this cycle.
- `mem_addr`  out  32  memory address.
- `pc`  out  32  current PC.
- `alu_out`  out  32  ALUOut register.
- `instr`  out  32  IR contents.
- `op`  out  6  `instr[31:26]`.
- `Funct`  out  6  `instr[5:0]`.
- `rs`  out  5  `instr[25:21]`.
- `rt`  out  5  `instr[20:16]`.
- `rd`  out  5  `instr[15:11]`.
- `imm_sext`  out  32  `instr[15:0]` sign-extended.
- `mdr`  out  32  MDR.
- `ir_valid`  out  1  at least one instruction captured since reset.
- `stall`  out  1  fetch pending; high in state WAIT.
- `mem_err`  out  1  sticky fetch-timeout flag.

## Operation
- **Reset.** All registers reset asynchronously on `rst` low, with these values:
  - `pc` = `RESET_PC`, `instr` = `RESET_IR`.
  - `alu_out`, `mdr` = 0.
  - `ir_valid`, `stall`, `mem_err` = 0.
  - state IDLE, wait counter 0, `req_addr` = 0.
- **ALUOut.** Loads `alu_result` every cycle. No enable.
- **PC update.**
  - Load enable is `PC_write | (Branch & zero)`.
  - Load value is `Pc_src_mux ? alu_out : alu_result`.
  - 32-bit modulo arithmetic; no alignment check.
  - PC updates are independent of the fetch FSM, including during WAIT.
- **Memory address.**
  - In IDLE: `mem_addr = lorD_mux ? alu_out : pc`, combinational.
  - In WAIT: `mem_addr = req_addr`, frozen for the whole fetch.
- **MDR.** Loads `mem_rdata` on every cycle `mem_ready` = 1, in any state.
- **Fetch FSM, 2 states.**
  - IDLE, `IR_write` = 1, `mem_ready` = 1: `instr <= mem_rdata`, set `ir_valid`, stay IDLE.
  - IDLE, `IR_write` = 1, `mem_ready` = 0: `req_addr <= mem_addr`, counter <= 1, go to WAIT.
  - IDLE, `IR_write` = 0: no IR change.
  - WAIT, `mem_ready` = 1: `instr <= mem_rdata`, set `ir_valid`, go to IDLE.
  - WAIT, `mem_ready` = 0 and counter = `MAX_WAIT`: set `mem_err`, go to IDLE, `instr` unchanged.
  - WAIT, otherwise: counter +1.
  - `IR_write` in WAIT is ignored; a request is already pending.
- **Decode.** Field outputs are purely combinational from `instr`. `imm_sext` = {16{`instr[15]`}, `instr[15:0]`}.
- **Error flag.** `mem_err` clears only on reset.

## Timing
- Same-cycle outputs (zero-latency paths):
  - `mem_addr` follows `lorD_mux`/`pc`/`alu_out` combinationally in IDLE.
  - `op`/`Funct` change in the same cycle as `instr`.
- One-edge latencies:
  - IR hit: `instr` and `op` are visible one edge after the edge where `IR_write` and `mem_ready` are sampled high.
  - Miss with ready arriving on the N-th WAIT cycle: `instr` updates on the edge that ends that WAIT cycle. `stall` is high for exactly N cycles.
  - PC load: new `pc` is visible the cycle after the enabling edge.
  - `alu_out` lags `alu_result` by one cycle.
- Timeout: `stall` is high for `MAX_WAIT` cycles. `mem_err` rises on the edge that leaves WAIT.
- Simultaneous events:
  - PC load and fetch request in the same cycle: the fetch uses the old `pc` (the pre-edge `mem_addr`).
  - `mem_ready` with `IR_write` = 0 in IDLE updates MDR only.
- Reset asserted mid-WAIT: immediate return to IDLE.
  - `stall` drops asynchronously.
  - `instr` returns to `RESET_IR`.
  - A late `mem_ready` after reset release, with `IR_write` = 0, does not touch `instr`.

## Test plan
- Reset: `rst` = 0 mid-run -> `pc` = 0, `instr` = 0, `op` = 0, `Funct` = 0, `stall` = 0, `ir_valid` = 0, `mem_err` = 0, same cycle.
- Zero-wait fetch: `mem_rdata` = 32'h2008_0005, `IR_write` = 1, `mem_ready` = 1 -> next cycle:
  - `op` = 6'b001000, `rt` = 8, `imm_sext` = 5, `ir_valid` = 1.
- 3-cycle miss: `IR_write` pulse at pc = 4, `mem_ready` low 3 cycles then high with 32'h012A_4020 ->
  - `stall` high exactly 3 cycles, `mem_addr` held at 4 while PC_write moves pc to 8.
  - `Funct` = 6'b100000, `rd` = 8.
- Timeout (`MAX_WAIT` = 4), `mem_ready` held 0 -> `stall` high 4 cycles, `mem_err` = 1, `instr` unchanged, FSM back in IDLE.
- PC control:
  - `Branch` = 1, `zero` = 0 -> pc unchanged.
  - `Branch` = 1, `zero` = 1, `Pc_src_mux` = 1, `alu_out` = 32'h40 -> pc = 32'h40.
  - `PC_write` with `alu_result` = 32'hFFFF_FFFC + 4 result 0 -> pc = 0 (wrap).
- `lorD_mux` = 1 with `alu_out` = 32'h100 and `mem_ready` = 1, `IR_write` = 0 -> `mem_addr` = 32'h100, `mdr` = `mem_rdata` next cycle, `instr` unchanged.
